// File: rtl/adpll_pkg.sv
// Shared types and default constants for the ADPLL acquisition/lock sequencer.
package adpll_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_LOOP_RST = 3'd1,
        ST_COARSE   = 3'd2,
        ST_FINE     = 3'd3,
        ST_LOCKED   = 3'd4
    } state_e;

    typedef struct packed {
        logic pll_reset;
        logic pll_enable;
        logic kp;
        logic ki;
        logic locked;
    } loop_ctrl_t;

    localparam int DEF_ERROR_WIDTH   = 8;
    localparam int DEF_COARSE_THRESH = 8;
    localparam int DEF_LOCK_THRESH   = 2;
    localparam int DEF_LOCK_COUNT    = 16;
    localparam int DEF_UNLOCK_COUNT  = 4;
    localparam int DEF_RESET_CYCLES  = 16;
    localparam int DEF_TIMEOUT_EDGES = 1024;

    // Loop control pins are a pure function of the state (Moore).
    function automatic loop_ctrl_t decode_ctrl(input state_e st);
        loop_ctrl_t c;
        c = '{pll_reset: 1'b1, pll_enable: 1'b0, kp: 1'b0, ki: 1'b0, locked: 1'b0};
        unique case (st)
            ST_LOOP_RST: c.pll_enable = 1'b1;
            ST_COARSE:   c = '{pll_reset: 1'b0, pll_enable: 1'b1, kp: 1'b1, ki: 1'b1, locked: 1'b0};
            ST_FINE:     c = '{pll_reset: 1'b0, pll_enable: 1'b1, kp: 1'b0, ki: 1'b0, locked: 1'b0};
            ST_LOCKED:   c = '{pll_reset: 1'b0, pll_enable: 1'b1, kp: 1'b0, ki: 1'b0, locked: 1'b1};
            default:     ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/adpll_ref_sampler.sv
// Brings the asynchronous reference clock into fpga_clk_i and captures the
// phase error once per reference rising edge as a one-cycle valid sample.
module adpll_ref_sampler #(
    parameter int ERROR_WIDTH = 8
) (
    input  logic                          fpga_clk_i,
    input  logic                          reset_i,
    input  logic                          ref_clk_i,
    input  logic signed [ERROR_WIDTH-1:0] error_i,
    output logic                          sample_valid_o,
    output logic signed [ERROR_WIDTH-1:0] sample_err_o
);

    logic ref_meta;
    logic ref_sync;
    logic ref_prev;
    logic ref_rise;

    assign ref_rise = ref_sync & ~ref_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge fpga_clk_i) begin
        if (!reset_i) begin
            ref_meta       <= 1'b0;
            ref_sync       <= 1'b0;
            ref_prev       <= 1'b0;
            sample_valid_o <= 1'b0;
            sample_err_o   <= '0;
        end else begin
            ref_meta       <= ref_clk_i;
            ref_sync       <= ref_meta;
            ref_prev       <= ref_sync;
            sample_valid_o <= ref_rise;
            if (ref_rise) begin
                sample_err_o <= error_i;
            end
        end
    end

endmodule

// File: rtl/adpll_lock_sequencer.sv
// ADPLL acquisition/lock FSM: OFF -> LOOP_RST -> COARSE -> FINE -> LOCKED.
// Define ADPLL_LOCK_TIMEOUT_EN to re-reset the loop if acquisition stalls.
module adpll_lock_sequencer
    import adpll_pkg::*;
#(
    parameter int ERROR_WIDTH   = DEF_ERROR_WIDTH,
    parameter int COARSE_THRESH = DEF_COARSE_THRESH,
    parameter int LOCK_THRESH   = DEF_LOCK_THRESH,
    parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
    parameter int UNLOCK_COUNT  = DEF_UNLOCK_COUNT,
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES
`ifdef ADPLL_LOCK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_EDGES = DEF_TIMEOUT_EDGES
`endif
) (
    input  logic                   fpga_clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   ref_clk_i,
    input  logic [ERROR_WIDTH-1:0] error_i,
    output logic                   pll_reset_o,
    output logic                   pll_enable_o,
    output logic                   kp_o,
    output logic                   ki_o,
    output logic                   locked_o,
    output logic [2:0]             state_o
);

    localparam int EW = ERROR_WIDTH;
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(UNLOCK_COUNT + 1);
    localparam int RW = $clog2(RESET_CYCLES + 1);

    localparam logic signed [EW-1:0] MOST_NEG   = {1'b1, {(EW-1){1'b0}}};
    localparam logic [EW-1:0]        MAX_POS    = {1'b0, {(EW-1){1'b1}}};
    localparam logic [EW-1:0]        COARSE_LIM = EW'(COARSE_THRESH);
    localparam logic [EW-1:0]        LOCK_LIM   = EW'(LOCK_THRESH);
    localparam logic [CW-1:0]        RUN_MAX    = CW'(LOCK_COUNT);
    localparam logic [CW-1:0]        RUN_LAST   = CW'(LOCK_COUNT - 1);
    localparam logic [MW-1:0]        MISS_MAX   = MW'(UNLOCK_COUNT);
    localparam logic [MW-1:0]        MISS_LAST  = MW'(UNLOCK_COUNT - 1);
    localparam logic [RW-1:0]        RST_MAX    = RW'(RESET_CYCLES);
    localparam logic [RW-1:0]        RST_LAST   = RW'(RESET_CYCLES - 1);

    state_e                 state_q, state_d;
    loop_ctrl_t             ctrl_q, ctrl_d;
    logic                   sample_valid;
    logic signed [EW-1:0]   sample_err;
    logic [EW-1:0]          mag;
    logic                   in_coarse, in_lock;
    logic [CW-1:0]          run_cnt;
    logic [MW-1:0]          miss_cnt;
    logic [RW-1:0]          rst_cnt;
    logic                   timeout_hit;

    adpll_ref_sampler #(.ERROR_WIDTH(EW)) u_ref_sampler (
        .fpga_clk_i     (fpga_clk_i),
        .reset_i        (reset_i),
        .ref_clk_i      (ref_clk_i),
        .error_i        ($signed(error_i)),
        .sample_valid_o (sample_valid),
        .sample_err_o   (sample_err)
    );

    // Saturating magnitude: the most negative code has no positive twin.
    always_comb begin
        if (sample_err == MOST_NEG) begin
            mag = MAX_POS;
        end else if (sample_err[EW-1]) begin
            mag = $unsigned(-sample_err);
        end else begin
            mag = $unsigned(sample_err);
        end
    end

    assign in_coarse = (mag <= COARSE_LIM);
    assign in_lock   = (mag <= LOCK_LIM);

`ifdef ADPLL_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_EDGES + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_EDGES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_EDGES - 1);

    logic [TW-1:0] tmo_cnt;
    logic          acquiring;

    assign acquiring   = (state_q == ST_COARSE) || (state_q == ST_FINE);
    assign timeout_hit = acquiring && sample_valid && (tmo_cnt >= TMO_LAST);

    // Spans COARSE<->FINE bounces so a loop that never settles is caught.
    always_ff @(posedge fpga_clk_i) begin
        if (!reset_i || !((state_d == ST_COARSE) || (state_d == ST_FINE))) begin
            tmo_cnt <= '0;
        end else if (acquiring && sample_valid && tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge fpga_clk_i) begin
        if (!reset_i) begin
            state_q <= ST_OFF;
            ctrl_q  <= decode_ctrl(ST_OFF);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_OFF;
        end else if (timeout_hit) begin
            state_d = ST_LOOP_RST;
        end else begin
            unique case (state_q)
                ST_OFF:      state_d = ST_LOOP_RST;
                ST_LOOP_RST: if (rst_cnt >= RST_LAST) state_d = ST_COARSE;
                ST_COARSE:   if (sample_valid && in_coarse && run_cnt >= RUN_LAST) state_d = ST_FINE;
                ST_FINE: begin
                    if (sample_valid && !in_coarse)                         state_d = ST_COARSE;
                    else if (sample_valid && in_lock && run_cnt >= RUN_LAST) state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (sample_valid && !in_coarse)                            state_d = ST_COARSE;
                    else if (sample_valid && !in_lock && miss_cnt >= MISS_LAST) state_d = ST_FINE;
                end
                default:     state_d = ST_OFF;
            endcase
        end
    end

    // Decoding the next state keeps registered outputs aligned with state_o.
    always_comb begin
        ctrl_d = decode_ctrl(state_d);
    end

    always_ff @(posedge fpga_clk_i) begin
        if (!reset_i || state_d != state_q) begin
            run_cnt  <= '0;
            miss_cnt <= '0;
            rst_cnt  <= '0;
        end else begin
            unique case (state_q)
                ST_LOOP_RST: if (rst_cnt != RST_MAX) rst_cnt <= rst_cnt + 1'b1;
                ST_COARSE, ST_FINE: begin
                    if (sample_valid) begin
                        if (!(state_q == ST_COARSE ? in_coarse : in_lock)) run_cnt <= '0;
                        else if (run_cnt != RUN_MAX)                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (sample_valid) begin
                        if (in_lock)                miss_cnt <= '0;
                        else if (miss_cnt != MISS_MAX) miss_cnt <= miss_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pll_reset_o  = ctrl_q.pll_reset;
    assign pll_enable_o = ctrl_q.pll_enable;
    assign kp_o         = ctrl_q.kp;
    assign ki_o         = ctrl_q.ki;
    assign locked_o     = ctrl_q.locked;
    assign state_o      = state_q;

endmodule

// File: tb/tb_adpll_lock_sequencer.sv
// Scoreboard bench: each reference edge pushes the predicted state; a monitor
// pops it once the sample has propagated and compares against the DUT.
module tb_adpll_lock_sequencer;

    logic       fpga_clk_i = 1'b0;
    logic       reset_i    = 1'b0;
    logic       enable_i   = 1'b1;
    logic       ref_clk_i  = 1'b0;
    logic [7:0] error_i    = '0;
    logic       pll_reset_o, pll_enable_o, kp_o, ki_o, locked_o;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit per_cycle_en = 1'b0;

    int m_state, m_run, m_miss;
    int exp_q[$];

    always #5 fpga_clk_i = ~fpga_clk_i;

    adpll_lock_sequencer dut (
        .fpga_clk_i   (fpga_clk_i),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .ref_clk_i    (ref_clk_i),
        .error_i      (error_i),
        .pll_reset_o  (pll_reset_o),
        .pll_enable_o (pll_enable_o),
        .kp_o         (kp_o),
        .ki_o         (ki_o),
        .locked_o     (locked_o),
        .state_o      (state_o)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // {pll_reset, pll_enable, kp, ki, locked} required in each state.
    function automatic int ctrl_for(input int st);
        case (st)
            0: return 5'b10000;
            1: return 5'b11000;
            2: return 5'b01110;
            3: return 5'b01000;
            4: return 5'b01001;
            default: return -1;
        endcase
    endfunction

    function automatic int mag_of(input int e);
        if (e == -128) return 127;
        return (e < 0) ? -e : e;
    endfunction

    // Reference model: one call per reference sample, thresholds 8 / 2,
    // runs of 16 to advance, 4 misses to drop lock.
    function automatic void model_step(input int e);
        int m;
        m = mag_of(e);
        case (m_state)
            2: begin
                m_run = (m <= 8) ? m_run + 1 : 0;
                if (m_run >= 16) begin m_state = 3; m_run = 0; end
            end
            3: begin
                if (m > 8) begin m_state = 2; m_run = 0; end
                else begin
                    m_run = (m <= 2) ? m_run + 1 : 0;
                    if (m_run >= 16) begin m_state = 4; m_run = 0; end
                end
            end
            4: begin
                if (m > 8) begin m_state = 2; m_miss = 0; end
                else begin
                    m_miss = (m > 2) ? m_miss + 1 : 0;
                    if (m_miss >= 4) begin m_state = 3; m_miss = 0; end
                end
            end
            default: ;
        endcase
    endfunction

    task automatic send_sample(input int e);
        model_step(e);
        exp_q.push_back(m_state);
        @(negedge fpga_clk_i);
        error_i = e[7:0];
        repeat (2) @(negedge fpga_clk_i);
        ref_clk_i = 1'b1;
        repeat (4) @(negedge fpga_clk_i);
        ref_clk_i = 1'b0;
        repeat (4) @(negedge fpga_clk_i);
    endtask

    // Expects to be called at a negedge with the DUT heading for LOOP_RST.
    task automatic run_startup(input string tag);
        int n, guard;
        n = 0;
        guard = 0;
        while (state_o != 3'd1 && guard < 50) begin
            @(negedge fpga_clk_i);
            guard++;
        end
        check({tag, "_enter_loop_rst"}, state_o, 1);
        while (state_o == 3'd1 && n < 100) begin
            n++;
            @(negedge fpga_clk_i);
        end
        check({tag, "_loop_rst_cycles"}, n, 16);
        check({tag, "_coarse_state"}, state_o, 2);
        check({tag, "_coarse_kp_ki"}, {kp_o, ki_o}, 2'b11);
        m_state = 2;
        m_run   = 0;
        m_miss  = 0;
    endtask

    always @(negedge fpga_clk_i) begin
        if (per_cycle_en) begin
            check("ctrl_vs_state", {pll_reset_o, pll_enable_o, kp_o, ki_o, locked_o}, ctrl_for(state_o));
        end
    end

    // Monitor: a sample reaches state_o four fpga_clk_i edges after the ref edge.
    initial begin
        forever begin
            @(posedge ref_clk_i);
            repeat (6) @(posedge fpga_clk_i);
            @(negedge fpga_clk_i);
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                check("state_after_sample", state_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        m_state = 0;
        m_run   = 0;
        m_miss  = 0;

        repeat (4) @(negedge fpga_clk_i);
        per_cycle_en = 1'b1;
        check("reset_state", state_o, 0);
        check("reset_pll_reset", pll_reset_o, 1);
        check("reset_locked", locked_o, 0);
        reset_i = 1'b1;
        run_startup("boot");

        // Inclusive COARSE bound, run clear on 9, then advance to FINE.
        for (int i = 0; i < 15; i++) send_sample(8);
        send_sample(9);
        for (int i = 0; i < 16; i++) send_sample(-8);
        check("boot_fine", state_o, 3);
        for (int i = 0; i < 20; i++) send_sample(5);
        check("fine_hold_at_5", state_o, 3);
        for (int i = 0; i < 16; i++) send_sample((i % 3 == 0) ? -2 : ((i % 3 == 1) ? 1 : 2));
        check("locked_state", state_o, 4);
        check("locked_flag", locked_o, 1);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) send_sample(3);
            send_sample(0);
        end
        check("locked_survives_3_misses", state_o, 4);
        for (int i = 0; i < 4; i++) send_sample(-3);
        check("unlock_to_fine", state_o, 3);
        check("unlock_flag", locked_o, 0);

        for (int i = 0; i < 16; i++) send_sample(1);
        check("relock", state_o, 4);
        send_sample(-128);
        check("saturated_to_coarse", state_o, 2);
        check("saturated_kp_ki", {kp_o, ki_o}, 2'b11);

        for (int i = 0; i < 16; i++) send_sample(int'($urandom_range(3, 8)) * ((i % 2) ? -1 : 1));
        check("fine_before_disable", state_o, 3);
        @(negedge fpga_clk_i);
        enable_i = 1'b0;
        @(negedge fpga_clk_i);
        check("disable_off", state_o, 0);
        check("disable_pll_reset", pll_reset_o, 1);
        repeat (3) @(negedge fpga_clk_i);
        enable_i = 1'b1;
        run_startup("reenable");

        for (int i = 0; i < 40; i++) send_sample(50);
        check("no_timeout_coarse", state_o, 2);

        // Randomised run biased towards small errors so LOCKED is visited.
        for (int i = 0; i < 300; i++) begin
            int p, e;
            p = int'($urandom_range(0, 99));
            if (p < 88)      e = int'($urandom_range(0, 2));
            else if (p < 97) e = int'($urandom_range(3, 8));
            else if (p < 99) e = int'($urandom_range(9, 127));
            else             e = 128;
            if ($urandom_range(0, 1) == 1) e = -e;
            if (e == 128) e = -128;
            send_sample(e);
        end

        @(negedge fpga_clk_i);
        reset_i = 1'b0;
        @(negedge fpga_clk_i);
        check("midrun_reset_state", state_o, 0);
        check("midrun_reset_locked", locked_o, 0);
        check("midrun_reset_pll_reset", pll_reset_o, 1);
        reset_i = 1'b1;
        run_startup("midrun");

        repeat (4) @(negedge fpga_clk_i);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
